// File: rtl/sq_store_queue.sv
// Circular store queue: tracks stores from dispatch through cache drain and
// builds the store-to-load forwarding candidate vector for the priority selector.
module sq_store_queue #(
    parameter int SQ_SIZE = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         disp_en,
    output logic [$clog2(SQ_SIZE)-1:0]   disp_idx,
    output logic                         full,
    output logic                         empty,
    input  logic                         ex_valid,
    input  logic [$clog2(SQ_SIZE)-1:0]   ex_idx,
    input  logic [ADDR_W-1:0]            ex_addr,
    input  logic [DATA_W-1:0]            ex_data,
    input  logic                         rt_en,
    input  logic                         squash,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    input  logic                         mem_ack,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [$clog2(SQ_SIZE)-1:0]   ld_tail,
    output logic [SQ_SIZE-1:0]           fwd_req,
    output logic [$clog2(SQ_SIZE)-1:0]   fwd_sel,
    input  logic [$clog2(SQ_SIZE)-1:0]   fwd_gnt,
    output logic                         fwd_hit,
    output logic                         fwd_stall,
    output logic [DATA_W-1:0]            fwd_data
);

    localparam int N  = SQ_SIZE;
    localparam int IW = $clog2(SQ_SIZE);
    localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
    localparam logic [IW:0]       CNT_ONE   = (IW+1)'(1);
    localparam logic [IW:0]       CNT_FULL  = (IW+1)'(N);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_ALLOC  = 2'd1,
        S_READY  = 2'd2,
        S_COMMIT = 2'd3
    } entry_st_e;

    entry_st_e         state_q [N];
    entry_st_e         state_d [N];
    logic [ADDR_W-1:0] addr_q  [N];
    logic [ADDR_W-1:0] addr_d  [N];
    logic [DATA_W-1:0] data_q  [N];
    logic [DATA_W-1:0] data_d  [N];
    logic [IW-1:0]     head_q, head_d;
    logic [IW-1:0]     cmt_q, cmt_d;
    logic [IW-1:0]     tail_q, tail_d;
    logic [IW:0]       count_q, count_d;

    logic disp_ok, ex_ok, rt_ok, ack_ok;
    logic [IW-1:0] fwd_lim, ent_off;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign disp_idx = tail_q;
    assign mem_req  = (state_q[head_q] == S_COMMIT);
    assign mem_addr = addr_q[head_q];
    assign mem_data = data_q[head_q];

    assign disp_ok = disp_en && !full && !squash;
    assign ex_ok   = ex_valid && !squash && (state_q[ex_idx] == S_ALLOC);
    assign rt_ok   = rt_en && (state_q[cmt_q] == S_READY);
    assign ack_ok  = mem_ack && mem_req;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        cmt_d   = cmt_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (disp_ok) begin
            state_d[tail_q] = S_ALLOC;
            tail_d          = tail_q + IDX_ONE;
        end
        if (ex_ok) begin
            state_d[ex_idx] = S_READY;
            addr_d[ex_idx]  = ex_addr;
            data_d[ex_idx]  = ex_data;
        end
        if (rt_ok) begin
            state_d[cmt_q] = S_COMMIT;
            cmt_d          = cmt_q + IDX_ONE;
        end
        if (ack_ok) begin
            state_d[head_q] = S_FREE;
            head_d          = head_q + IDX_ONE;
        end

        if (disp_ok && !ack_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!disp_ok && ack_ok) begin
            count_d = count_q - CNT_ONE;
        end

        // Retire has already been folded in, so a same-cycle retiree survives.
        if (squash) begin
            count_d = '0;
            for (int i = 0; i < N; i++) begin
                if (state_d[i] == S_ALLOC || state_d[i] == S_READY) begin
                    state_d[i] = S_FREE;
                end
                if (state_d[i] == S_COMMIT) begin
                    count_d = count_d + CNT_ONE;
                end
            end
            tail_d = cmt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= S_FREE;
            end
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Age test: an entry is older than the load when its ring offset from head
    // is below the load's tail snapshot offset.
    always_comb begin
        fwd_req   = '0;
        fwd_stall = 1'b0;
        ent_off   = '0;
        fwd_lim   = ld_tail - head_q;
        for (int i = 0; i < N; i++) begin
            ent_off = IW'(i) - head_q;
            if (ent_off < fwd_lim) begin
                if ((state_q[i] == S_READY || state_q[i] == S_COMMIT) &&
                    (((addr_q[i] ^ ld_addr) & WORD_MASK) == '0)) begin
                    fwd_req[i] = 1'b1;
                end
                if (state_q[i] == S_ALLOC) begin
                    fwd_stall = 1'b1;
                end
            end
        end
    end

    assign fwd_sel  = ld_tail - IDX_ONE;
    assign fwd_hit  = (|fwd_req) && !fwd_stall;
    assign fwd_data = data_q[fwd_gnt];

endmodule

// File: tb/tb_sq_store_queue.sv
// Bench for sq_store_queue: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the in-flight stores.
module tb_sq_store_queue;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          disp_en, ex_valid, rt_en, squash, mem_ack;
    logic [IW-1:0] ex_idx, ld_tail, fwd_gnt, disp_idx, fwd_sel;
    logic [AW-1:0] ex_addr, ld_addr, mem_addr;
    logic [DW-1:0] ex_data, mem_data, fwd_data;
    logic          full, empty, mem_req, fwd_hit, fwd_stall;
    logic [N-1:0]  fwd_req;

    sq_store_queue #(.SQ_SIZE(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .disp_en(disp_en), .disp_idx(disp_idx), .full(full), .empty(empty),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_addr(ex_addr), .ex_data(ex_data),
        .rt_en(rt_en), .squash(squash),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_tail(ld_tail), .fwd_req(fwd_req), .fwd_sel(fwd_sel),
        .fwd_gnt(fwd_gnt), .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data)
    );

    always #5 clock = ~clock;

    // Model: stores in age order (front = head); committed stores form a prefix.
    typedef struct {
        int            idx;
        bit            res;
        bit            cmt;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rec_t;

    rec_t mq[$];
    int   head_m, tail_m, lt_cur;
    int   n_chk, n_fail;
    logic [AW-1:0] addr_pool [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int first_uncommitted();
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].cmt) return k;
        end
        return -1;
    endfunction

    function automatic bit rt_legal();
        int c;
        c = first_uncommitted();
        if (c < 0) return 1'b0;
        return mq[c].res;
    endfunction

    task automatic step(input bit de, input bit exv, input int exi, input logic [AW-1:0] exa,
                        input logic [DW-1:0] exd, input bit rt, input bit sq, input bit ack,
                        input logic [AW-1:0] la, input int lt);
        int            no, gk, c;
        logic [N-1:0]  ereq;
        bit            est, mreq, dacc, racc, aacc;
        rec_t          keep[$];
        rec_t          nr;
        @(negedge clock);
        if (rt) assert (rt_legal()) else $error("FAIL rt_protocol retire of unresolved store");
        disp_en  = de;
        ex_valid = exv;
        ex_idx   = exi[IW-1:0];
        ex_addr  = exa;
        ex_data  = exd;
        rt_en    = rt;
        squash   = sq;
        mem_ack  = ack;
        ld_addr  = la;
        ld_tail  = lt[IW-1:0];
        lt_cur   = lt;

        // Expected forwarding from age order: the first (lt-head) mod N stores are older.
        no = (lt - head_m + N) % N;
        if (no > mq.size()) no = mq.size();
        ereq = '0;
        est  = 1'b0;
        gk   = -1;
        for (int k = 0; k < no; k++) begin
            if (!mq[k].res) est = 1'b1;
            else if (mq[k].addr[AW-1:2] == la[AW-1:2]) begin
                ereq[mq[k].idx] = 1'b1;
                gk = k;
            end
        end
        fwd_gnt = (gk >= 0) ? mq[gk].idx[IW-1:0] : IW'($urandom_range(0, N-1));
        #1;

        mreq = (mq.size() > 0) && mq[0].cmt;
        chk("disp_idx", disp_idx, tail_m);
        chk("full", full, mq.size() == N);
        chk("empty", empty, mq.size() == 0);
        chk("mem_req", mem_req, mreq);
        if (mreq) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            chk("mem_data", mem_data, mq[0].data);
        end
        chk("fwd_req", fwd_req, ereq);
        chk("fwd_stall", fwd_stall, est);
        chk("fwd_hit", fwd_hit, (ereq != 0) && !est);
        chk("fwd_sel", fwd_sel, (lt + N - 1) % N);
        if ((ereq != 0) && !est) chk("fwd_data", fwd_data, mq[gk].data);

        // Advance the model by one clock.
        dacc = de && !sq && (mq.size() < N);
        c    = first_uncommitted();
        racc = rt && (c >= 0) && rt_legal();
        aacc = ack && mreq;
        if (exv && !sq) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].idx == exi && !mq[k].res) begin
                    mq[k].res  = 1'b1;
                    mq[k].addr = exa;
                    mq[k].data = exd;
                end
            end
        end
        if (racc) mq[c].cmt = 1'b1;
        if (aacc) begin
            void'(mq.pop_front());
            head_m = (head_m + 1) % N;
        end
        if (sq) begin
            foreach (mq[k]) if (mq[k].cmt) keep.push_back(mq[k]);
            mq = keep;
            tail_m = (mq.size() > 0) ? (mq[mq.size()-1].idx + 1) % N : head_m;
        end
        if (dacc) begin
            nr.idx  = tail_m;
            nr.res  = 1'b0;
            nr.cmt  = 1'b0;
            nr.addr = '0;
            nr.data = '0;
            mq.push_back(nr);
            tail_m = (tail_m + 1) % N;
        end
        @(posedge clock);
    endtask

    task automatic idle(input logic [AW-1:0] la, input int lt);
        step(0, 0, 0, '0, '0, 0, 0, 0, la, lt);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_fwd_req", fwd_req, '0);
        chk("rst_fwd_hit", fwd_hit, 1'b0);
        chk("rst_fwd_stall", fwd_stall, 1'b0);
        chk("rst_disp_idx", disp_idx, 0);
        chk("rst_fwd_sel", fwd_sel, (lt_cur + N - 1) % N);
        mq.delete();
        head_m = 0;
        tail_m = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int   unres[$];
        int   c, exi;
        bit   de, exv, rt, sq, ack;

        n_chk = 0; n_fail = 0; lt_cur = 0;
        disp_en = 0; ex_valid = 0; ex_idx = '0; ex_addr = '0; ex_data = '0;
        rt_en = 0; squash = 0; mem_ack = 0; ld_addr = '0; ld_tail = '0; fwd_gnt = '0;
        addr_pool[0] = 32'h100; addr_pool[1] = 32'h103;
        addr_pool[2] = 32'h104; addr_pool[3] = 32'h200;
        repeat (2) @(posedge clock);
        do_reset();

        // Fill all eight entries, then a ninth dispatch must be ignored.
        for (int i = 0; i < 9; i++) step(1, 0, 0, '0, '0, 0, 0, 0, '0, 0);
        idle(32'h100, 3);
        #1;
        chk("plan_full", full, 1'b1);
        chk("plan_disp_idx_wrap", disp_idx, 0);

        // Entry 1 unresolved -> stall; once resolved, entries 0 and 2 forward.
        step(0, 1, 0, 32'h100, 32'hA, 0, 0, 0, '0, 0);
        step(0, 1, 2, 32'h100, 32'hB, 0, 0, 0, '0, 0);
        idle(32'h100, 3);
        #1;
        chk("plan_stall", fwd_stall, 1'b1);
        chk("plan_stall_hit", fwd_hit, 1'b0);
        step(0, 1, 1, 32'h200, 32'hC, 0, 0, 0, '0, 0);
        idle(32'h100, 3);
        #1;
        chk("plan_fwd_req", fwd_req, 8'b0000_0101);
        chk("plan_fwd_sel", fwd_sel, 2);
        chk("plan_fwd_nostall", fwd_stall, 1'b0);
        chk("plan_fwd_data", fwd_data, 32'hB);

        // Retire 0 and 1, hold the cache ack low, then accept entry 0.
        step(0, 0, 0, '0, '0, 1, 0, 0, '0, 0);
        step(0, 0, 0, '0, '0, 1, 0, 0, '0, 0);
        repeat (3) idle('0, 0);
        #1;
        chk("plan_hold_req", mem_req, 1'b1);
        chk("plan_hold_addr", mem_addr, 32'h100);
        chk("plan_hold_data", mem_data, 32'hA);
        step(0, 0, 0, '0, '0, 0, 0, 1, '0, 0);
        #1;
        chk("plan_next_req", mem_req, 1'b1);
        chk("plan_next_addr", mem_addr, 32'h200);

        // Drain through entry 5, refill 0..3 and query across the wrap.
        step(0, 0, 0, '0, '0, 0, 0, 1, '0, 0);
        for (int i = 3; i < 6; i++) step(0, 1, i, 32'h900 + 32'(i), 32'(i), 0, 0, 0, '0, 0);
        repeat (4) step(0, 0, 0, '0, '0, 1, 0, 0, '0, 0);
        repeat (4) step(0, 0, 0, '0, '0, 0, 0, 1, '0, 0);
        repeat (4) step(1, 0, 0, '0, '0, 0, 0, 0, '0, 0);
        step(0, 1, 6, 32'h300, 32'hC6, 0, 0, 0, '0, 0);
        step(0, 1, 7, 32'h500, 32'hC7, 0, 0, 0, '0, 0);
        step(0, 1, 0, 32'h600, 32'hC0, 0, 0, 0, '0, 0);
        step(0, 1, 1, 32'h300, 32'hD1, 0, 0, 0, '0, 0);
        idle(32'h300, 2);
        #1;
        chk("plan_wrap_req", fwd_req, 8'b0100_0010);
        chk("plan_wrap_sel", fwd_sel, 1);
        chk("plan_wrap_data", fwd_data, 32'hD1);

        // Squash with two committed stores, then drain them.
        repeat (2) step(0, 0, 0, '0, '0, 1, 0, 0, '0, 0);
        step(0, 1, 2, 32'h700, 32'hE2, 0, 0, 0, '0, 0);
        step(0, 0, 0, '0, '0, 0, 1, 0, '0, 0);
        #1;
        chk("plan_sq_tail", disp_idx, 0);
        chk("plan_sq_empty", empty, 1'b0);
        chk("plan_sq_req", mem_req, 1'b1);
        repeat (2) step(0, 0, 0, '0, '0, 0, 0, 1, '0, 0);
        #1;
        chk("plan_sq_drained", empty, 1'b1);

        // Reset while a store is requesting drain.
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, 0);
        step(0, 1, 0, 32'h700, 32'hE, 0, 0, 0, '0, 0);
        step(0, 0, 0, '0, '0, 1, 0, 0, '0, 0);
        idle('0, 0);
        #1;
        chk("plan_pre_rst_req", mem_req, 1'b1);
        do_reset();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            unres.delete();
            foreach (mq[k]) if (!mq[k].res) unres.push_back(mq[k].idx);
            de  = ($urandom_range(0, 99) < 55);
            exv = ($urandom_range(0, 99) < 60);
            if (unres.size() > 0 && $urandom_range(0, 3) != 0)
                exi = unres[$urandom_range(0, unres.size() - 1)];
            else
                exi = $urandom_range(0, N - 1);
            rt = 1'b0;
            c  = first_uncommitted();
            if (c >= 0) begin
                if (mq[c].res && $urandom_range(0, 1) == 1) rt = 1'b1;
            end
            sq  = ($urandom_range(0, 99) < 3);
            ack = ($urandom_range(0, 1) == 1);
            step(de, exv, exi, addr_pool[$urandom_range(0, 3)], $urandom, rt, sq, ack,
                 addr_pool[$urandom_range(0, 3)], $urandom_range(0, N - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
